// File: rtl/datapath_types.sv
// Next-PC controller states, source encoding, JTB size and the fixed-priority
// source selection helper.
package datapath_types;

    localparam int JTB_ENTRIES = 16;

    typedef enum logic [1:0] {
        RUN,
        PEND,
        SWEEP
    } next_pc_state_t;

    typedef enum logic [2:0] {
        SRC_EXE,
        SRC_RAS,
        SRC_JTB,
        SRC_SEQ,
        SRC_HOLD
    } next_pc_src_t;

    // A return request with an empty RAS wins over the JTB but redirects nowhere.
    function automatic next_pc_src_t select_src(
        input logic exe_redirect,
        input logic ras_pop_req,
        input logic ras_empty,
        input logic jtb_hit,
        input logic fetch_ready
    );
        next_pc_src_t src;
        if (exe_redirect) begin
            src = SRC_EXE;
        end else if (ras_pop_req && !ras_empty) begin
            src = SRC_RAS;
        end else if (ras_pop_req) begin
            src = fetch_ready ? SRC_SEQ : SRC_HOLD;
        end else if (jtb_hit && fetch_ready) begin
            src = SRC_JTB;
        end else if (fetch_ready) begin
            src = SRC_SEQ;
        end else begin
            src = SRC_HOLD;
        end
        return src;
    endfunction

endpackage

// File: rtl/rv32i_types.sv
// Basic RV32I word type shared by the fetch-side blocks.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

endpackage

// File: rtl/jtb_sweep_counter.sv
// JTB invalidation index counter: start/restart forces zero, enable steps by one,
// done flags the last index.
module jtb_sweep_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_en,
    output logic [W-1:0] o_idx,
    output logic         o_done
);

    logic [W-1:0] r_idx;

    always_ff @(posedge clk) begin
        if (i_rst || i_start) begin
            r_idx <= '0;
        end else if (i_en) begin
            r_idx <= r_idx + W'(1);
        end
    end

    assign o_idx  = r_idx;
    assign o_done = (r_idx == {W{1'b1}});

endmodule

// File: rtl/next_pc_ctrl.sv
// Fetch-stage next-PC controller with pending-redirect hold and JTB sweep.
// Optional macro NEXT_PC_PERF_EN adds saturating performance counters.
module next_pc_ctrl
    import rv32i_types::*;
    import datapath_types::*;
#(
    parameter rv32i_word RESET_PC  = 32'h0000_0060,
    parameter int        JTB_IDX_W = $clog2(JTB_ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_ready,
    input  logic                 jtb_hit,
    input  rv32i_word            jtb_target,
    input  logic                 ras_pop_req,
    input  rv32i_word            ras_top,
    input  logic                 ras_empty,
    input  logic                 exe_redirect,
    input  rv32i_word            exe_target,
    input  logic                 fence_i,
    output rv32i_word            pc_out,
    output logic                 fetch_valid,
    output logic                 flush_if,
    output logic                 flush_id,
    output logic                 ras_pop,
    output logic                 jtb_inv,
    output logic [JTB_IDX_W-1:0] jtb_inv_idx,
    output logic                 busy
`ifdef NEXT_PC_PERF_EN
    ,
    output logic [31:0]          perf_jtb_hits,
    output logic [31:0]          perf_ras_pops,
    output logic [31:0]          perf_redirects
`endif
);

    next_pc_state_t r_state, w_state_next;
    rv32i_word      r_pc, w_pc_next;
    rv32i_word      r_pend_pc, w_pend_pc_next;
    logic           r_pend_valid, w_pend_valid_next;

    next_pc_src_t         w_src;
    rv32i_word            w_redir_tgt;
    logic                 w_cnt_start;
    logic                 w_cnt_en;
    logic [JTB_IDX_W-1:0] w_cnt_idx;
    logic                 w_cnt_done;

    assign w_src       = select_src(exe_redirect, ras_pop_req, ras_empty, jtb_hit, fetch_ready);
    assign w_redir_tgt = exe_redirect ? exe_target : ras_top;

    jtb_sweep_counter #(
        .W (JTB_IDX_W)
    ) u_sweep_cnt (
        .clk     (clk),
        .i_rst   (rst),
        .i_start (w_cnt_start),
        .i_en    (w_cnt_en),
        .o_idx   (w_cnt_idx),
        .o_done  (w_cnt_done)
    );

    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_pend_pc_next    = r_pend_pc;
        w_pend_valid_next = r_pend_valid;
        w_cnt_start       = 1'b0;
        w_cnt_en          = 1'b0;
        fetch_valid       = 1'b0;
        flush_if          = 1'b0;
        flush_id          = 1'b0;
        ras_pop           = 1'b0;
        jtb_inv           = 1'b0;
        jtb_inv_idx       = '0;
        busy              = 1'b0;

        if (!rst) begin
            // An execute redirect is accepted in every state (to pc_out or pending).
            if (exe_redirect) begin
                flush_if = 1'b1;
                flush_id = 1'b1;
            end

            case (r_state)
                RUN: begin
                    fetch_valid = 1'b1;
                    if (fence_i) begin
                        w_state_next = SWEEP;
                        w_cnt_start  = 1'b1;
                        if (exe_redirect) begin
                            w_pend_pc_next    = exe_target;
                            w_pend_valid_next = 1'b1;
                        end
                    end else begin
                        case (w_src)
                            SRC_EXE, SRC_RAS: begin
                                if (w_src == SRC_RAS) begin
                                    flush_if = 1'b1;
                                    ras_pop  = 1'b1;
                                end
                                if (fetch_ready) begin
                                    w_pc_next = w_redir_tgt;
                                end else begin
                                    w_pend_pc_next    = w_redir_tgt;
                                    w_pend_valid_next = 1'b1;
                                    w_state_next      = PEND;
                                end
                            end
                            SRC_JTB: w_pc_next = jtb_target;
                            SRC_SEQ: w_pc_next = r_pc + 32'd4;
                            default: ;
                        endcase
                    end
                end

                PEND: begin
                    if (exe_redirect) begin
                        w_pend_pc_next = exe_target;
                    end
                    if (fence_i) begin
                        w_state_next = SWEEP;
                        w_cnt_start  = 1'b1;
                    end else if (fetch_ready) begin
                        w_pc_next         = w_pend_pc_next;
                        w_pend_valid_next = 1'b0;
                        w_state_next      = RUN;
                    end
                end

                SWEEP: begin
                    busy        = 1'b1;
                    jtb_inv     = 1'b1;
                    jtb_inv_idx = w_cnt_idx;
                    w_cnt_en    = 1'b1;
                    if (exe_redirect) begin
                        w_pend_pc_next    = exe_target;
                        w_pend_valid_next = 1'b1;
                    end
                    if (fence_i) begin
                        w_cnt_start = 1'b1;
                    end else if (w_cnt_done) begin
                        w_state_next = w_pend_valid_next ? PEND : RUN;
                    end
                end

                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= SWEEP;
            r_pc         <= RESET_PC;
            r_pend_pc    <= '0;
            r_pend_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_pend_pc    <= w_pend_pc_next;
            r_pend_valid <= w_pend_valid_next;
        end
    end

    assign pc_out = r_pc;

`ifdef NEXT_PC_PERF_EN
    logic [2:0]  w_perf_inc;
    logic [31:0] r_perf_cnt [3];

    assign w_perf_inc[0] = !rst && (r_state == RUN) && !fence_i && (w_src == SRC_JTB);
    assign w_perf_inc[1] = ras_pop;
    assign w_perf_inc[2] = !rst && exe_redirect;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_perf
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_perf_cnt[gi] <= '0;
                end else if (w_perf_inc[gi] && (r_perf_cnt[gi] != 32'hFFFF_FFFF)) begin
                    r_perf_cnt[gi] <= r_perf_cnt[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign perf_jtb_hits  = r_perf_cnt[0];
    assign perf_ras_pops  = r_perf_cnt[1];
    assign perf_redirects = r_perf_cnt[2];
`endif

endmodule

// File: tb/tb_next_pc_ctrl.sv
// Self-checking bench for next_pc_ctrl: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the next-PC rules.
module tb_next_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_ready;
    logic        jtb_hit;
    logic [31:0] jtb_target;
    logic        ras_pop_req;
    logic [31:0] ras_top;
    logic        ras_empty;
    logic        exe_redirect;
    logic [31:0] exe_target;
    logic        fence_i;
    logic [31:0] pc_out;
    logic        fetch_valid;
    logic        flush_if;
    logic        flush_id;
    logic        ras_pop;
    logic        jtb_inv;
    logic [3:0]  jtb_inv_idx;
    logic        busy;

    always #5 clk = ~clk;

    next_pc_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_ready  (fetch_ready),
        .jtb_hit      (jtb_hit),
        .jtb_target   (jtb_target),
        .ras_pop_req  (ras_pop_req),
        .ras_top      (ras_top),
        .ras_empty    (ras_empty),
        .exe_redirect (exe_redirect),
        .exe_target   (exe_target),
        .fence_i      (fence_i),
        .pc_out       (pc_out),
        .fetch_valid  (fetch_valid),
        .flush_if     (flush_if),
        .flush_id     (flush_id),
        .ras_pop      (ras_pop),
        .jtb_inv      (jtb_inv),
        .jtb_inv_idx  (jtb_inv_idx),
        .busy         (busy)
    );

    int n_vec     = 0;
    int n_err     = 0;
    int flush_cnt = 0;

    // Model: sweep position (-1 when idle), an optional waiting redirect, the PC.
    logic [31:0] m_pc;
    logic [31:0] m_pend_pc;
    bit          m_pend_have;
    bit          m_known = 1'b0;
    int          m_sweep = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_cycle();
        bit fv, fi, fd, rp, inv, bsy;
        int idx;
        fv = 0; fi = 0; fd = 0; rp = 0; inv = 0; bsy = 0; idx = 0;
        if (m_known) chk("pc", pc_out, m_pc);
        if (rst) begin
            m_pc = 32'h60; m_sweep = 0; m_pend_have = 0; m_pend_pc = 0; m_known = 1;
        end else if (m_sweep >= 0) begin
            bsy = 1; inv = 1; idx = m_sweep;
            if (exe_redirect) begin
                fi = 1; fd = 1; m_pend_pc = exe_target; m_pend_have = 1;
            end
            if (fence_i) m_sweep = 0;
            else if (m_sweep == 15) m_sweep = -1;
            else m_sweep++;
        end else if (m_pend_have) begin
            if (exe_redirect) begin
                fi = 1; fd = 1; m_pend_pc = exe_target;
            end
            if (fence_i) m_sweep = 0;
            else if (fetch_ready) begin
                m_pc = m_pend_pc; m_pend_have = 0;
            end
        end else begin
            fv = 1;
            if (fence_i) begin
                m_sweep = 0;
                if (exe_redirect) begin
                    fi = 1; fd = 1; m_pend_pc = exe_target; m_pend_have = 1;
                end
            end else if (exe_redirect || (ras_pop_req && !ras_empty)) begin
                logic [31:0] tgt;
                tgt = exe_redirect ? exe_target : ras_top;
                fi = 1; fd = exe_redirect; rp = !exe_redirect;
                if (fetch_ready) m_pc = tgt;
                else begin
                    m_pend_pc = tgt; m_pend_have = 1;
                end
            end else if (ras_pop_req) begin
                if (fetch_ready) m_pc = m_pc + 4;
            end else if (jtb_hit && fetch_ready) begin
                m_pc = jtb_target;
            end else if (fetch_ready) begin
                m_pc = m_pc + 4;
            end
        end
        chk("ctl", {26'd0, fetch_valid, flush_if, flush_id, ras_pop, jtb_inv, busy},
                   {26'd0, fv, fi, fd, rp, inv, bsy});
        chk("idx", {28'd0, jtb_inv_idx}, 32'(idx));
    endtask

    task automatic cycle();
        @(negedge clk);
        model_cycle();
        if (flush_id === 1'b1) flush_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        fetch_ready = 0; jtb_hit = 0; jtb_target = 0; ras_pop_req = 0; ras_top = 0;
        ras_empty = 0; exe_redirect = 0; exe_target = 0; fence_i = 0;
    endtask

    initial begin
        logic [31:0] r;
        rst = 1;
        clear_in();
        cycle();
        cycle();

        // Power-up sweep, then sequential fetch from the reset PC
        rst = 0;
        fetch_ready = 1;
        for (int i = 0; i < 16; i++) cycle();
        chk("t1_pc0", pc_out, 32'h60);
        chk("t1_fv", {31'd0, fetch_valid}, 32'd1);
        cycle();
        chk("t1_pc1", pc_out, 32'h64);
        cycle();
        chk("t1_pc2", pc_out, 32'h68);

        // Priority collision
        exe_redirect = 1; exe_target = 32'h200;
        ras_pop_req = 1; ras_top = 32'h300;
        jtb_hit = 1; jtb_target = 32'h400;
        #1;
        chk("t2_flush", {29'd0, flush_if, flush_id, ras_pop}, 32'b110);
        cycle();
        chk("t2_pc", pc_out, 32'h200);

        // Held redirect overwritten while stalled
        clear_in();
        flush_cnt = 0;
        exe_redirect = 1; exe_target = 32'h500;
        cycle();
        exe_redirect = 0;
        cycle();
        exe_redirect = 1; exe_target = 32'h600;
        cycle();
        exe_redirect = 0; fetch_ready = 1;
        cycle();
        chk("t3_pc", pc_out, 32'h600);
        chk("t3_flushes", 32'(flush_cnt), 32'd2);

        // Return with empty RAS
        exe_redirect = 1; exe_target = 32'h80;
        cycle();
        exe_redirect = 0; ras_pop_req = 1; ras_empty = 1; ras_top = 32'h900;
        #1;
        chk("t4_raspop", {31'd0, ras_pop}, 32'd0);
        cycle();
        chk("t4_pc", pc_out, 32'h84);

        // PC wrap-around
        clear_in();
        fetch_ready = 1; exe_redirect = 1; exe_target = 32'hFFFF_FFFC;
        cycle();
        exe_redirect = 0;
        cycle();
        chk("t6_pc", pc_out, 32'h0);

        // fence.i together with a redirect, JTB hits ignored during sweep
        fence_i = 1; exe_redirect = 1; exe_target = 32'h700;
        jtb_hit = 1; jtb_target = 32'h400;
        cycle();
        fence_i = 0; exe_redirect = 0;
        for (int i = 0; i < 16; i++) cycle();
        chk("t5_hold", pc_out, 32'h0);
        cycle();
        chk("t5_pc", pc_out, 32'h700);

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            rst          = ($urandom_range(0, 199) == 0);
            fence_i      = ($urandom_range(0, 59) == 0);
            exe_redirect = ($urandom_range(0, 7) == 0);
            ras_pop_req  = ($urandom_range(0, 5) == 0);
            ras_empty    = ($urandom_range(0, 2) == 0);
            jtb_hit      = ($urandom_range(0, 3) == 0);
            fetch_ready  = ($urandom_range(0, 3) != 0);
            r = $urandom(); r[1:0] = 2'b00; exe_target = r;
            r = $urandom(); r[1:0] = 2'b00; ras_top = r;
            r = $urandom(); r[1:0] = 2'b00; jtb_target = r;
            cycle();
        end

        rst = 0;
        clear_in();
        cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
